// File: rtl/prm_edge_mask_drain_if.sv
// prm_edge_mask_drain_if
// Groups the query, checker-broadcast and word-stream signals of prm_edge_mask_drain.
//   master : query/abort source, checker array (edge_mask_in) and planner (word_ready)
//   slave  : prm_edge_mask_drain itself
// Signals:
//   query_code/query_valid/query_ready : query request handshake
//   abort                              : synchronous abort of the current query
//   chk_code                           : code broadcast to every checker
//   edge_mask_in                       : edge_mask of checker i on bit i
//   word_data/word_valid/word_ready    : snapshot word stream
//   word_last/word_idx                 : final-word flag and word index
//   blocked_cnt/cnt_valid              : popcount of last full snapshot, update pulse
interface prm_edge_mask_drain_if #(
  parameter int unsigned NUM_EDGE = 512,
  parameter int unsigned OUT_W    = 32
);
  localparam int unsigned NWORDS = NUM_EDGE / OUT_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_EDGE + 1);

  logic [14:0]         query_code;
  logic                query_valid;
  logic                query_ready;
  logic                abort;
  logic [14:0]         chk_code;
  logic [NUM_EDGE-1:0] edge_mask_in;
  logic [OUT_W-1:0]    word_data;
  logic                word_valid;
  logic                word_ready;
  logic                word_last;
  logic [IDX_W-1:0]    word_idx;
  logic [CNT_W-1:0]    blocked_cnt;
  logic                cnt_valid;

  modport master (
    output query_code, query_valid, abort, edge_mask_in, word_ready,
    input  query_ready, chk_code, word_data, word_valid, word_last, word_idx,
           blocked_cnt, cnt_valid
  );

  modport slave (
    input  query_code, query_valid, abort, edge_mask_in, word_ready,
    output query_ready, chk_code, word_data, word_valid, word_last, word_idx,
           blocked_cnt, cnt_valid
  );
endinterface

// File: rtl/prm_edge_mask_drain.sv
// prm_edge_mask_drain
// Broadcasts an obstacle code to the checker array, waits CHK_LAT cycles for the
// edge masks to settle, snapshots them and streams the snapshot as OUT_W-bit words,
// then reports the number of blocked edges.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : prm_edge_mask_drain_if.slave (query, checker broadcast, word stream, count)
module prm_edge_mask_drain #(
  parameter int unsigned NUM_EDGE = 512,
  parameter int unsigned OUT_W    = 32,
  parameter int unsigned CHK_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  prm_edge_mask_drain_if.slave  bus
);
  localparam int unsigned NWORDS = NUM_EDGE / OUT_W;
  localparam int unsigned IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int unsigned CNT_W  = $clog2(NUM_EDGE + 1);
  localparam int unsigned PC_W   = $clog2(OUT_W + 1);
  localparam int unsigned SET_W  = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);
  localparam logic [SET_W-1:0] SET_INIT = SET_W'(CHK_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_STREAM} state_t;

  state_t              r_state;
  logic [14:0]         r_chk_code;
  logic [NUM_EDGE-1:0] r_snapshot;
  logic [IDX_W-1:0]    r_idx;
  logic                r_valid;
  logic                r_query_ready;
  logic [SET_W-1:0]    r_settle;
  logic [CNT_W-1:0]    r_sum;
  logic [CNT_W-1:0]    r_blocked;
  logic                r_cnt_valid;

  logic [OUT_W-1:0]    w_word;
  logic [PC_W-1:0]     w_pop;
  logic [CNT_W-1:0]    w_sum_next;
  logic                w_last;
  logic                w_hs;

  assign w_word     = r_snapshot[r_idx*OUT_W +: OUT_W];
  assign w_last     = r_valid && (r_idx == LAST_IDX);
  assign w_hs       = r_valid && bus.word_ready;
  assign w_sum_next = r_sum + CNT_W'(w_pop);

  always_comb begin
    w_pop = '0;
    for (int unsigned i = 0; i < OUT_W; i++) begin
      w_pop = w_pop + PC_W'(w_word[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_chk_code    <= '0;
      r_snapshot    <= '0;
      r_idx         <= '0;
      r_valid       <= 1'b0;
      r_query_ready <= 1'b1;
      r_settle      <= '0;
      r_sum         <= '0;
      r_blocked     <= '0;
      r_cnt_valid   <= 1'b0;
    end else begin
      r_cnt_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.query_valid) begin
            r_chk_code    <= bus.query_code;
            r_settle      <= SET_INIT;
            r_sum         <= '0;
            r_query_ready <= 1'b0;
            r_state       <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          // abort wins over a same-cycle capture
          if (bus.abort) begin
            r_query_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else if (r_settle == '0) begin
            r_snapshot <= bus.edge_mask_in;
            r_idx      <= '0;
            r_valid    <= 1'b1;
            r_state    <= S_STREAM;
          end else begin
            r_settle <= r_settle - 1'b1;
          end
        end
        S_STREAM: begin
          // abort wins over a same-cycle handshake; partial sum is dropped
          if (bus.abort) begin
            r_valid       <= 1'b0;
            r_idx         <= '0;
            r_sum         <= '0;
            r_query_ready <= 1'b1;
            r_state       <= S_IDLE;
          end else if (w_hs) begin
            if (w_last) begin
              r_blocked     <= w_sum_next;
              r_cnt_valid   <= 1'b1;
              r_valid       <= 1'b0;
              r_idx         <= '0;
              r_query_ready <= 1'b1;
              r_state       <= S_IDLE;
            end else begin
              r_sum <= w_sum_next;
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        default: begin
          r_valid       <= 1'b0;
          r_query_ready <= 1'b1;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.query_ready = r_query_ready;
  assign bus.chk_code    = r_chk_code;
  assign bus.word_data   = w_word;
  assign bus.word_valid  = r_valid;
  assign bus.word_last   = w_last;
  assign bus.word_idx    = r_idx;
  assign bus.blocked_cnt = r_blocked;
  assign bus.cnt_valid   = r_cnt_valid;
endmodule

// File: tb/tb_prm_edge_mask_drain.sv
module tb_prm_edge_mask_drain;
  logic clk;
  logic rst_n;
  logic [63:0] mask_src;

  int n_chk;
  int n_fail;
  logic [63:0] exp_blk;

  prm_edge_mask_drain_if #(.NUM_EDGE(64), .OUT_W(32)) bus ();

  prm_edge_mask_drain #(.NUM_EDGE(64), .OUT_W(32), .CHK_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stand-in for the checker array: mask appears one cycle after being presented
  always @(posedge clk) bus.edge_mask_in <= mask_src;

  typedef struct {
    logic [14:0] code;
    logic [63:0] mask;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [63:0] cnt;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (bus.query_ready !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk("wait_query_ready", bus.query_ready, 1'b1);
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    v = vecs[k];
    wait_ready();
    mask_src        = v.mask;
    bus.word_ready  = 1'b1;
    bus.query_code  = v.code;
    bus.query_valid = 1'b1;
    tick();                       // accept edge T
    bus.query_valid = 1'b0;
    chk("chk_code", bus.chk_code, v.code);
    chk("qready_settle", bus.query_ready, 1'b0);
    chk("valid_T1", bus.word_valid, 1'b0);
    tick();
    chk("valid_T2m", bus.word_valid, 1'b0);
    tick();                       // T+CHK_LAT: first word
    chk("w0_valid", bus.word_valid, 1'b1);
    chk("w0_idx", bus.word_idx, 1'b0);
    chk("w0_data", bus.word_data, v.w0);
    chk("w0_last", bus.word_last, 1'b0);
    tick();
    chk("w1_valid", bus.word_valid, 1'b1);
    chk("w1_idx", bus.word_idx, 1'b1);
    chk("w1_data", bus.word_data, v.w1);
    chk("w1_last", bus.word_last, 1'b1);
    tick();
    chk("done_valid", bus.word_valid, 1'b0);
    chk("done_cnt_valid", bus.cnt_valid, 1'b1);
    chk("done_blocked", bus.blocked_cnt, v.cnt);
    chk("done_qready", bus.query_ready, 1'b1);
    tick();
    chk("cnt_valid_pulse", bus.cnt_valid, 1'b0);
    chk("blocked_hold", bus.blocked_cnt, v.cnt);
    exp_blk = v.cnt;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    vecs[0] = '{15'h4A21, 64'h0000_0003_8000_0001, 32'h8000_0001, 32'h0000_0003, 64'd4};
    vecs[1] = '{15'h7FFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd64};
    vecs[2] = '{15'h0000, 64'h0000_0000_0000_0000, 32'h0000_0000, 32'h0000_0000, 64'd0};
    vecs[3] = '{15'h1234, 64'h00FF_0000_F0F0_0001, 32'hF0F0_0001, 32'h00FF_0000, 64'd17};

    rst_n           = 1'b0;
    mask_src        = '0;
    bus.query_code  = '0;
    bus.query_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.word_ready  = 1'b0;
    tick();
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_qready", bus.query_ready, 1'b1);
    chk("rst_chk_code", bus.chk_code, 15'h0);
    chk("rst_valid", bus.word_valid, 1'b0);
    chk("rst_last", bus.word_last, 1'b0);
    chk("rst_idx", bus.word_idx, 1'b0);
    chk("rst_blocked", bus.blocked_cnt, 7'd0);
    chk("rst_cnt_valid", bus.cnt_valid, 1'b0);

    for (int i = 0; i < 4; i++) run_vec(i);

    // reset during word 0
    mask_src        = vecs[3].mask;
    bus.word_ready  = 1'b0;
    bus.query_code  = vecs[3].code;
    bus.query_valid = 1'b1;
    tick();
    bus.query_valid = 1'b0;
    tick();
    tick();
    chk("mid_valid_pre", bus.word_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", bus.word_valid, 1'b0);
    chk("mid_rst_chk_code", bus.chk_code, 15'h0);
    chk("mid_rst_idx", bus.word_idx, 1'b0);
    chk("mid_rst_last", bus.word_last, 1'b0);
    chk("mid_rst_blocked", bus.blocked_cnt, 7'd0);
    chk("mid_rst_cnt_valid", bus.cnt_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_rst_qready", bus.query_ready, 1'b1);
    chk("mid_rst_valid_after", bus.word_valid, 1'b0);

    run_vec(0);

    // backpressure on word 0, mask changes after capture
    mask_src        = vecs[0].mask;
    bus.word_ready  = 1'b0;
    bus.query_code  = vecs[0].code;
    bus.query_valid = 1'b1;
    tick();
    bus.query_valid = 1'b0;
    tick();
    tick();
    mask_src = '1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.word_valid, 1'b1);
      chk("bp_idx", bus.word_idx, 1'b0);
      chk("bp_data", bus.word_data, 32'h8000_0001);
      tick();
    end
    bus.word_ready = 1'b1;
    chk("bp_data_release", bus.word_data, 32'h8000_0001);
    tick();
    chk("bp_w1_idx", bus.word_idx, 1'b1);
    chk("bp_w1_data", bus.word_data, 32'h0000_0003);
    tick();
    chk("bp_cnt_valid", bus.cnt_valid, 1'b1);
    chk("bp_blocked", bus.blocked_cnt, 7'd4);
    exp_blk = 64'd4;

    // abort in SETTLE
    mask_src        = '1;
    bus.query_code  = 15'h0555;
    bus.query_valid = 1'b1;
    tick();
    bus.query_valid = 1'b0;
    bus.abort       = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_settle_qready", bus.query_ready, 1'b1);
    chk("ab_settle_valid", bus.word_valid, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("ab_settle_no_valid", bus.word_valid, 1'b0);
      chk("ab_settle_no_cnt", bus.cnt_valid, 1'b0);
      chk("ab_settle_blocked", bus.blocked_cnt, exp_blk);
      tick();
    end

    // abort coincident with last handshake
    bus.word_ready  = 1'b1;
    bus.query_code  = 15'h0AAA;
    bus.query_valid = 1'b1;
    tick();
    bus.query_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("ab_last_pre", bus.word_last, 1'b1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("ab_last_valid", bus.word_valid, 1'b0);
    chk("ab_last_cnt", bus.cnt_valid, 1'b0);
    chk("ab_last_blocked", bus.blocked_cnt, exp_blk);
    chk("ab_last_idx", bus.word_idx, 1'b0);
    chk("ab_last_qready", bus.query_ready, 1'b1);
    tick();
    chk("ab_last_cnt2", bus.cnt_valid, 1'b0);
    chk("ab_last_blocked2", bus.blocked_cnt, exp_blk);

    // back-to-back with query_valid held high
    mask_src        = vecs[0].mask;
    bus.word_ready  = 1'b1;
    bus.query_code  = 15'h0101;
    bus.query_valid = 1'b1;
    tick();                       // T
    chk("b2b_code1", bus.chk_code, 15'h0101);
    bus.query_code = 15'h0202;
    tick();
    chk("b2b_hold_settle", bus.chk_code, 15'h0101);
    tick();
    chk("b2b_hold_stream", bus.chk_code, 15'h0101);
    chk("b2b_w0", bus.word_data, 32'h8000_0001);
    tick();
    chk("b2b_last", bus.word_last, 1'b1);
    tick();                       // last handshake taken
    chk("b2b_qready", bus.query_ready, 1'b1);
    chk("b2b_code_still1", bus.chk_code, 15'h0101);
    chk("b2b_cnt_valid1", bus.cnt_valid, 1'b1);
    tick();                       // second accept
    chk("b2b_code2", bus.chk_code, 15'h0202);
    chk("b2b_qready_low", bus.query_ready, 1'b0);
    bus.query_valid = 1'b0;
    tick();
    tick();
    chk("b2b2_w0", bus.word_data, 32'h8000_0001);
    tick();
    chk("b2b2_w1", bus.word_data, 32'h0000_0003);
    tick();
    chk("b2b2_cnt_valid", bus.cnt_valid, 1'b1);
    chk("b2b2_blocked", bus.blocked_cnt, 7'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
